muldiv_unit: RTL and testbench

- Parametrised multi-cycle multiply/divide unit that owns the architectural HI/LO registers.
- Replaces the single-cycle combinational MULT/DIV path in the execute stage with:
  - a MUL_LAT-cycle multiplier
  - a radix-2 iterative divider
- Raises busy so the pipeline stalls while an operation is in flight.
- Supports flush for squashed instructions.

---
 rtl/muldiv_pkg.sv | 29 ++
 rtl/muldiv_div_core.sv | 61 ++++++
 rtl/muldiv_unit.sv | 160 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the multi-cycle multiply/divide unit: op codes, FSM states
// and the counter-width helper.
package muldiv_pkg;

  typedef enum logic [2:0] {
    MD_NOP   = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } md_state_e;

  // The shared down-counter must hold both WIDTH-1 and MUL_LAT-1.
  function automatic int cnt_width(input int width, input int mul_lat);
    int m;
    m = (width > mul_lat) ? width : mul_lat;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Restoring radix-2 divider datapath: operand magnitudes, partial remainder and
// quotient shift register, plus the sign fix-up applied to the committed results.
module muldiv_div_core
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] rem, quo, dvs;
  logic             neg_q, neg_r;
  logic             a_neg, b_neg;
  logic [WIDTH:0]   trial, diff;

  always_comb begin
    a_neg = is_signed & dividend[WIDTH-1];
    b_neg = is_signed & divisor[WIDTH-1];
    // quo holds the not-yet-consumed dividend bits; its MSB feeds the remainder.
    trial = {rem, quo[WIDTH-1]};
    diff  = trial - {1'b0, dvs};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (load) begin
      rem   <= '0;
      quo   <= a_neg ? -dividend : dividend;
      dvs   <= b_neg ? -divisor : divisor;
      neg_q <= a_neg ^ b_neg;
      neg_r <= a_neg;
    end else if (step) begin
      if (!diff[WIDTH]) begin
        rem <= diff[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], 1'b1};
      end else begin
        rem <= trial[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign quotient  = neg_q ? -quo : quo;
  assign remainder = neg_r ? -rem : rem;

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/DIV unit owning HI/LO: MUL_LAT-cycle multiply, WIDTH-cycle
// restoring divide plus one sign fix-up cycle; busy stalls the pipeline meanwhile.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = cnt_width(WIDTH, MUL_LAT);

  md_state_e          state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   mul_a, mul_b;
  logic               mul_signed;
  logic [2*WIDTH-1:0] mul_ext_a, mul_ext_b, product;
  logic [WIDTH-1:0]   div_q, div_r;
  logic mul_go, div_go, dz_go, mthi_go, mtlo_go;
  logic mul_commit, div_commit, div_step;

  // NOTE: every signal driven here gets a default first, so no path through the
  // case statements can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt  = state;
    mul_go     = 1'b0;
    div_go     = 1'b0;
    dz_go      = 1'b0;
    mthi_go    = 1'b0;
    mtlo_go    = 1'b0;
    mul_commit = 1'b0;
    div_commit = 1'b0;
    div_step   = 1'b0;
    case (state)
      IDLE: begin
        if (start && !flush) begin
          case (md_op_e'(op))
            MD_MULT, MD_MULTU: begin
              mul_go    = 1'b1;
              state_nxt = MUL;
            end
            MD_DIV, MD_DIVU: begin
              if (src_b == '0) begin
                dz_go = 1'b1;
              end else begin
                div_go    = 1'b1;
                state_nxt = DIV;
              end
            end
            MD_MTHI: mthi_go = 1'b1;
            MD_MTLO: mtlo_go = 1'b1;
            default: ;
          endcase
        end
      end
      MUL: begin
        if (flush) begin
          state_nxt = IDLE;
        end else if (cnt == '0) begin
          mul_commit = 1'b1;
          state_nxt  = IDLE;
        end
      end
      DIV: begin
        if (flush) begin
          state_nxt = IDLE;
        end else begin
          div_step = 1'b1;
          if (cnt == '0) state_nxt = FIX;
        end
      end
      FIX: begin
        state_nxt  = IDLE;
        div_commit = !flush;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (mul_go) begin
      cnt <= CNT_W'(MUL_LAT - 1);
    end else if (div_go) begin
      cnt <= CNT_W'(WIDTH - 1);
    end else if ((state == MUL || state == DIV) && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Operands are held for the whole multiply; the product is formed at commit.
  always_comb begin
    mul_ext_a = mul_signed ? {{WIDTH{mul_a[WIDTH-1]}}, mul_a} : {{WIDTH{1'b0}}, mul_a};
    mul_ext_b = mul_signed ? {{WIDTH{mul_b[WIDTH-1]}}, mul_b} : {{WIDTH{1'b0}}, mul_b};
    product   = mul_ext_a * mul_ext_b;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_a      <= '0;
      mul_b      <= '0;
      mul_signed <= 1'b0;
    end else if (mul_go) begin
      mul_a      <= src_a;
      mul_b      <= src_b;
      mul_signed <= (md_op_e'(op) == MD_MULT);
    end
  end

  muldiv_div_core #(.WIDTH(WIDTH)) u_div_core (
    .clk       (clk),
    .rst       (rst),
    .load      (div_go),
    .step      (div_step),
    .is_signed (md_op_e'(op) == MD_DIV),
    .dividend  (src_a),
    .divisor   (src_b),
    .quotient  (div_q),
    .remainder (div_r)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done     <= mthi_go | mtlo_go | mul_commit | div_commit;
      div_zero <= dz_go;
      if (mthi_go) hi <= src_a;
      if (mtlo_go) lo <= src_a;
      if (mul_commit) {hi, lo} <= product;
      if (div_commit) begin
        hi <= div_r;
        lo <= div_q;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (WIDTH=32, MUL_LAT=3): latency, results, div-by-zero,
// busy/flush handling and asynchronous reset, with hand-computed expectations.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start, flush;
  logic [2:0]   op;
  logic [W-1:0] src_a, src_b;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [2:0]   op;
    logic [W-1:0] a, b, hi, lo;
  } vec_t;

  muldiv_unit #(.WIDTH(W), .MUL_LAT(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .flush    (flush),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  // Drives start during cycle 0; returns at the negedge of cycle 1.
  task automatic start_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(negedge clk);
    start = 1'b0; op = MD_NOP;
  endtask

  // Starting in cycle 1, counts busy cycles and finds the done cycle (-1 if none).
  task automatic wait_done(output int done_cyc, output int busy_cnt);
    done_cyc = -1;
    busy_cnt = 0;
    for (int c = 1; c <= 100; c++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cyc = c;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [W-1:0] got [5];
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = MD_NOP; src_a = '0; src_b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    got = '{W'(busy), W'(done), W'(div_zero), hi, lo};
    for (int i = 0; i < 5; i++) begin
      total++;
      if (got[i] !== '0) begin
        bad++;
        $display("FAIL reset[%0d] (busy,done,div_zero,hi,lo): got %h want 0", i, got[i]);
      end
    end
  endtask

  task automatic test_mult();
    vec_t v [2];
    int dc, bc;
    v[0] = '{MD_MULT,  32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA};
    v[1] = '{MD_MULTU, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA};
    for (int i = 0; i < 2; i++) begin
      start_op(v[i].op, v[i].a, v[i].b);
      wait_done(dc, bc);
      total += 4;
      if (dc !== 4) begin bad++; $display("FAIL mult[%0d] done cycle: got %0d want 4", i, dc); end
      if (bc !== 3) begin bad++; $display("FAIL mult[%0d] busy cycles: got %0d want 3", i, bc); end
      if (hi !== v[i].hi) begin bad++; $display("FAIL mult[%0d] hi: got %h want %h", i, hi, v[i].hi); end
      if (lo !== v[i].lo) begin bad++; $display("FAIL mult[%0d] lo: got %h want %h", i, lo, v[i].lo); end
    end
  endtask

  task automatic test_div();
    vec_t v [4];
    int dc, bc;
    v[0] = '{MD_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    v[1] = '{MD_DIVU, 32'd7,        32'd2,        32'd1,        32'd3};
    v[2] = '{MD_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    v[3] = '{MD_DIV,  32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
    for (int i = 0; i < 4; i++) begin
      start_op(v[i].op, v[i].a, v[i].b);
      wait_done(dc, bc);
      total += 4;
      if (dc !== 34) begin bad++; $display("FAIL div[%0d] done cycle: got %0d want 34", i, dc); end
      if (bc !== 33) begin bad++; $display("FAIL div[%0d] busy cycles: got %0d want 33", i, bc); end
      if (hi !== v[i].hi) begin bad++; $display("FAIL div[%0d] hi: got %h want %h", i, hi, v[i].hi); end
      if (lo !== v[i].lo) begin bad++; $display("FAIL div[%0d] lo: got %h want %h", i, lo, v[i].lo); end
    end
  endtask

  task automatic test_mt_div_zero();
    logic quiet;
    start_op(MD_MTHI, 32'h11, '0);
    total += 3;
    if (done !== 1'b1) begin bad++; $display("FAIL mthi done: got %b want 1", done); end
    if (busy !== 1'b0) begin bad++; $display("FAIL mthi busy: got %b want 0", busy); end
    if (hi !== 32'h11) begin bad++; $display("FAIL mthi hi: got %h want 11", hi); end
    start_op(MD_MTLO, 32'h22, '0);
    total += 3;
    if (done !== 1'b1) begin bad++; $display("FAIL mtlo done: got %b want 1", done); end
    if (lo !== 32'h22) begin bad++; $display("FAIL mtlo lo: got %h want 22", lo); end
    if (hi !== 32'h11) begin bad++; $display("FAIL mtlo hi kept: got %h want 11", hi); end
    start_op(MD_DIV, 32'd5, '0);
    total += 3;
    if (div_zero !== 1'b1) begin bad++; $display("FAIL divzero pulse: got %b want 1", div_zero); end
    if (done !== 1'b0) begin bad++; $display("FAIL divzero done: got %b want 0", done); end
    if (busy !== 1'b0) begin bad++; $display("FAIL divzero busy: got %b want 0", busy); end
    quiet = 1'b1;
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      if (busy || done || div_zero) quiet = 1'b0;
    end
    total += 3;
    if (quiet !== 1'b1) begin bad++; $display("FAIL divzero after: got %b want quiet 1", quiet); end
    if (hi !== 32'h11) begin bad++; $display("FAIL divzero hi: got %h want 11", hi); end
    if (lo !== 32'h22) begin bad++; $display("FAIL divzero lo: got %h want 22", lo); end
  endtask

  task automatic test_busy_flush();
    logic busy_ok, saw_done;
    int dc, bc;
    start_op(MD_MTHI, 32'h11, '0);
    start_op(MD_MTLO, 32'h22, '0);
    start_op(MD_DIV, 32'd100, 32'd3);
    busy_ok = 1'b1; saw_done = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      if (c <= 10 && !busy) busy_ok = 1'b0;
      if (done) saw_done = 1'b1;
      if (c == 11) begin
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL flush busy c11: got %b want 0", busy); end
      end
      start = (c == 5);
      op    = (c == 5) ? MD_MULT : MD_NOP;
      src_a = 32'd6; src_b = 32'd7;
      flush = (c == 10);
      @(negedge clk);
    end
    start = 1'b0; flush = 1'b0;
    total += 4;
    if (busy_ok !== 1'b1) begin bad++; $display("FAIL flush busy c1-10: got %b want 1", busy_ok); end
    if (saw_done !== 1'b0) begin bad++; $display("FAIL flush done seen: got %b want 0", saw_done); end
    if (hi !== 32'h11) begin bad++; $display("FAIL flush hi: got %h want 11", hi); end
    if (lo !== 32'h22) begin bad++; $display("FAIL flush lo: got %h want 22", lo); end
    start_op(MD_MULT, 32'd4, 32'd5);
    wait_done(dc, bc);
    total += 3;
    if (dc !== 4) begin bad++; $display("FAIL mult after flush done cycle: got %0d want 4", dc); end
    if (lo !== 32'd20) begin bad++; $display("FAIL mult after flush lo: got %h want 14", lo); end
    if (hi !== 32'd0) begin bad++; $display("FAIL mult after flush hi: got %h want 0", hi); end
  endtask

  task automatic test_async_reset();
    int dc, bc;
    start_op(MD_DIV, 32'd100, 32'd3);
    repeat (14) @(negedge clk);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL areset busy before: got %b want 1", busy); end
    #1 rst = 1'b1;
    #1;
    total += 4;
    if (busy !== 1'b0) begin bad++; $display("FAIL areset busy: got %b want 0", busy); end
    if (done !== 1'b0) begin bad++; $display("FAIL areset done: got %b want 0", done); end
    if (hi !== '0) begin bad++; $display("FAIL areset hi: got %h want 0", hi); end
    if (lo !== '0) begin bad++; $display("FAIL areset lo: got %h want 0", lo); end
    #1 rst = 1'b0;
    start_op(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(dc, bc);
    total += 3;
    if (dc !== 4) begin bad++; $display("FAIL multu post-reset done cycle: got %0d want 4", dc); end
    if (hi !== 32'hFFFFFFFE) begin bad++; $display("FAIL multu post-reset hi: got %h want fffffffe", hi); end
    if (lo !== 32'h00000001) begin bad++; $display("FAIL multu post-reset lo: got %h want 00000001", lo); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mt_div_zero();
    test_busy_flush();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
